// File: rtl/hyperfabric_pkg.sv
// Shared hyperfabric definitions: descriptor bit positions and event encoding.
package hyperfabric_pkg;

  // Descriptor bit 63: 1 while the transaction is live, 0 once it has ended.
  localparam int ACTIVE_BIT_DEF = 63;

  // Descriptor bit 61: ownership strobe a writer must match to update an entry.
  localparam int STROBE_BIT_DEF = 61;

  // Event type carried in the MSB of every event word.
  typedef enum logic {
    EVT_CPL = 1'b0,
    EVT_IRQ = 1'b1
  } evt_type_e;

  // A scheduler write owns the entry only if its strobe matches the stored one.
  function automatic logic strobe_match(input logic stored_bit, input logic req_bit);
    return stored_bit == req_bit;
  endfunction

endpackage

// File: rtl/hyper_evt_fifo.sv
// Event FIFO with two prioritised push ports (a before b) and one pop port.
// The head is presented first-word-fall-through from registered state.
module hyper_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             push_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             pop,
  input  logic             clr,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int DEPTH = 1 << LOG2;

  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    rd_ptr;
  logic [WIDTH-1:0] slots [DEPTH];

  logic [LOG2:0]    used;
  logic [LOG2+1:0]  free_cnt;
  logic [LOG2:0]    wr_ptr_b;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             acc_a;
  logic             acc_b;

  // Occupancy and push acceptance; a pop in the same cycle frees a slot for the pushes.
  always_comb begin
    used     = wr_ptr - rd_ptr;
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
               (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
    pop_ok   = pop && !empty;
    free_cnt = (LOG2+2)'(DEPTH) - {1'b0, used} + {{(LOG2+1){1'b0}}, pop_ok};
    acc_a    = push_a && (!full || pop_ok);
    acc_b    = push_b && (free_cnt > {{(LOG2+1){1'b0}}, acc_a});
    wr_ptr_b = wr_ptr + {{LOG2{1'b0}}, acc_a};
  end

  assign valid = !empty;
  assign head  = slots[rd_ptr[LOG2-1:0]];

  // Slot writes, pointer advance and sticky overflow (a dropped push beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (acc_a) begin
        slots[wr_ptr[LOG2-1:0]] <= data_a;
      end
      if (acc_b) begin
        slots[wr_ptr_b[LOG2-1:0]] <= data_b;
      end
      wr_ptr <= wr_ptr + {{LOG2{1'b0}}, acc_a} + {{LOG2{1'b0}}, acc_b};
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (LOG2+1)'(1);
      end
      if ((push_a && !acc_a) || (push_b && !acc_b)) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hyper_desc_mem.sv
// Descriptor table shared by the scheduler and the host.
// Scheduler writes are strobe-qualified and raise completion events when a
// descriptor goes inactive; interrupts are queued in the same event FIFO.
module hyper_desc_mem
  import hyperfabric_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 64,
  parameter int STROBE_BIT = STROBE_BIT_DEF,
  parameter int ACTIVE_BIT = ACTIVE_BIT_DEF,
  parameter int EVT_LOG2   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              READ_MEM,
  input  logic [ADDR_W-1:0] MEM_R_ADDR,
  output logic [DATA_W-1:0] MEM_R_DATA,
  input  logic              WRITE_MEM,
  input  logic [ADDR_W-1:0] MEM_W_ADDR,
  input  logic [DATA_W-1:0] MEM_W_DATA,
  input  logic              IRQ,
  input  logic [2:0]        IRQ_DESC,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  input  logic              HOST_RE,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_RVALID,
  output logic              HOST_CONFLICT,
  input  logic              EVT_POP,
  output logic              EVT_VALID,
  output logic [ADDR_W:0]   EVT_DATA,
  output logic              EVT_OVERFLOW,
  input  logic              EVT_CLR
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_vld_p0;
  logic [ADDR_W-1:0] rd_addr_p0;

  logic              wr_vld_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;

  logic              hw_vld_p0;
  logic [ADDR_W-1:0] hw_addr_p0;
  logic [DATA_W-1:0] hw_data_p0;

  logic              sched_commit;
  logic              host_commit;
  logic              host_drop;
  logic              cpl_push;
  logic [ADDR_W:0]   cpl_word;
  logic [ADDR_W:0]   irq_word;

  // Stage p0: capture scheduler read, scheduler write and host write requests.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_vld_p0  <= 1'b0;
      rd_addr_p0 <= '0;
      wr_vld_p0  <= 1'b0;
      wr_addr_p0 <= '0;
      wr_data_p0 <= '0;
      hw_vld_p0  <= 1'b0;
      hw_addr_p0 <= '0;
      hw_data_p0 <= '0;
    end else begin
      rd_vld_p0 <= READ_MEM;
      if (READ_MEM) begin
        rd_addr_p0 <= MEM_R_ADDR;
      end
      wr_vld_p0 <= WRITE_MEM;
      if (WRITE_MEM) begin
        wr_addr_p0 <= MEM_W_ADDR;
        wr_data_p0 <= MEM_W_DATA;
      end
      hw_vld_p0 <= HOST_WE;
      if (HOST_WE) begin
        hw_addr_p0 <= HOST_ADDR;
        hw_data_p0 <= HOST_WDATA;
      end
    end
  end

  // Commit decode: strobe ownership check, host/scheduler collision, event words.
  always_comb begin
    sched_commit = wr_vld_p0 &&
                   strobe_match(mem[wr_addr_p0][STROBE_BIT], wr_data_p0[STROBE_BIT]);
    host_drop    = hw_vld_p0 && sched_commit && (hw_addr_p0 == wr_addr_p0);
    host_commit  = hw_vld_p0 && !host_drop;
    cpl_push     = sched_commit && !wr_data_p0[ACTIVE_BIT];
    cpl_word     = {EVT_CPL, wr_addr_p0};
    irq_word     = {EVT_IRQ, ADDR_W'(IRQ_DESC)};
  end

  // Descriptor table; the scheduler and host may commit to different entries together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (host_commit) begin
        mem[hw_addr_p0] <= hw_data_p0;
      end
      if (sched_commit) begin
        mem[wr_addr_p0] <= wr_data_p0;
      end
    end
  end

  // Stage p1: scheduler read data, sampled before any same-edge commit lands.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MEM_R_DATA <= '0;
    end else if (rd_vld_p0) begin
      MEM_R_DATA <= mem[rd_addr_p0];
    end
  end

  // Host read port: one-cycle latency with a single-cycle valid pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HOST_RDATA  <= '0;
      HOST_RVALID <= 1'b0;
    end else begin
      HOST_RVALID <= HOST_RE;
      if (HOST_RE) begin
        HOST_RDATA <= mem[HOST_ADDR];
      end
    end
  end

  // Flag a host write that lost its entry to a scheduler commit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HOST_CONFLICT <= 1'b0;
    end else begin
      HOST_CONFLICT <= host_drop;
    end
  end

  hyper_evt_fifo #(
    .WIDTH (ADDR_W + 1),
    .LOG2  (EVT_LOG2)
  ) u_evt_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push_a   (cpl_push),
    .data_a   (cpl_word),
    .push_b   (IRQ),
    .data_b   (irq_word),
    .pop      (EVT_POP),
    .clr      (EVT_CLR),
    .valid    (EVT_VALID),
    .head     (EVT_DATA),
    .overflow (EVT_OVERFLOW)
  );

endmodule
